alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the CPU's single-cycle ALU.
- Adds operand width WIDTH, iterative nibble-serial BCD adjust for ADD/SUB, and multi-bit shifts/rotates executed one bit per cycle.
- Uses a start/busy/done handshake.
- Sits beside the CPU datapath and serves wide-word extensions and coprocessor-style ops; the CPU consumes result and flags selectively.

Parameters:
- WIDTH, 8, operand/result width; multiple of 4, range 8..32.
- CW, $clog2(WIDTH), width of shift-count input.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when busy=0.
- op  in  4  operation select, latched on accept.
- A  in  WIDTH  operand A, latched on accept.
- B  in  WIDTH  operand B, latched on accept.
- ci  in  1  carry in, latched on accept.
- dec  in  1  decimal mode; affects ADD/SUB only.
- cnt  in  CW  shift count for ASL/LSR/ROL/ROR, latched on accept.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  result; held until next completion.
- C  out  1  carry flag.
- Z  out  1  zero flag (result==0).
- N  out  1  result[WIDTH-1].
- V  out  1  overflow flag.

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, result=0, C=Z=N=V=0. Reset mid-operation aborts the operation; no done is produced.
- Ops:
  - 0 ADD: A+B+ci.
  - 1 SUB: A+~B+ci.
  - 2 AND, 3 OR, 4 EOR.
  - 5 ASL, 6 LSR, 7 ROL, 8 ROR.
  - 9 INC: A+1.
  - 10 DEC: A+all-ones.
  - 11 CMP: A+~B+1, dec ignored.
  - 12-15 reserved: result=A, C=ci, V=0.
- Binary flags: C = carry out of bit WIDTH-1. V = (Ai[msb]==Bi[msb]) && (R[msb]!=Ai[msb]), using the effective B input. Logic ops and shifts: V=0. Logic ops: C=ci.
- Accept: start=1 while busy=0 latches all inputs. busy rises the next cycle. start while busy=1 is ignored.
- FSM states: IDLE, BIN, BCD, SHF.
  - IDLE→BIN: binary ops, and ADD/SUB with dec=0. Compute in one cycle, then return to IDLE with done=1. Latency 1: done is high in the cycle after the accept edge.
  - IDLE→BCD: ADD/SUB with dec=1. One nibble per cycle, LSB first, for WIDTH/4 cycles; latency 1+WIDTH/4.
    - Nibble k: s = A_k + B'_k + c, 5 bits, where B'=B for ADD and ~B for SUB; c starts at ci.
    - ADD: if s>9, digit=(s+6)[3:0] and c=1; else digit=s, c=0.
    - SUB: c=s[4]; if c=0, digit=(s-6)[3:0]; else digit=s[3:0].
    - Final c drives C. Z and N come from the decimal result. V comes from the binary sum of the full operands.
    - Invalid BCD digits follow the same rule; no error is raised.
  - IDLE→SHF: one bit per cycle for cnt cycles.
    - ASL: {C,r}={r,0}. LSR: {r,C}={0,r}. ROL: {C,r}={r,C}. ROR: {r,C}={C,r}.
    - C is initialised from ci. Latency 1+cnt. cnt=0 gives result=A, C=ci, latency 1.
- Completion: result and flags update in the same cycle done=1. busy falls in that cycle. A new start is accepted in that same cycle (back-to-back).
- Outputs are registered. Intermediate values are not visible on result/flags while busy=1.

Test Plan:
- WIDTH=8, ADD dec=0, A=0x7F B=0x01 ci=0 -> result=0x80, C=0, V=1, N=1, Z=0; done exactly 1 cycle after accept.
- ADD dec=1, A=0x58 B=0x46 ci=1 -> result=0x05, C=1, N=0, V=1; busy for 3 cycles, done at cycle 3.
- SUB dec=1, A=0x12 B=0x21 ci=1 -> result=0x91, C=0, N=1. Then CMP A=0x40 B=0x40 -> result=0x00, Z=1, C=1, N=0.
- ROR cnt=3, A=0x01 ci=1 -> result=0x60, C=0; done 4 cycles after accept. A second start pulsed at cycle 2 is ignored. cnt=0 -> result=A, C=ci, latency 1.
- WIDTH=16, ADD dec=1, A=0x9999 B=0x0001 ci=0 -> result=0x0000, C=1, Z=1; latency 5.
- rst_n low for 1 cycle at cycle 2 of a decimal ADD -> all outputs 0 immediately, no done. After release, a new ADD 0x10+0x20 dec=0 -> 0x30 with done after 1 cycle.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the sequential ALU.
// The master issues start/operands; the slave reports busy/done/result/flags.
interface alu_seq_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ci;
    logic             dec;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             C;
    logic             Z;
    logic             N;
    logic             V;

    modport master (
        output start, op, A, B, ci, dec, cnt,
        input  busy, done, result, C, Z, N, V
    );

    modport slave (
        input  start, op, A, B, ci, dec, cnt,
        output busy, done, result, C, Z, N, V
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with nibble-serial BCD adjust and serial shifts.
// Results and flags are registered and only change on the done pulse.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int MSB = WIDTH - 1;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_INC = 4'd9;
    localparam logic [3:0] OP_DEC = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;

    typedef enum logic [1:0] {IDLE, BIN, BCD, SHF} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d;
    logic             cf_q, cf_d;
    logic             zf_q, zf_d;
    logic             nf_q, nf_d;
    logic             vf_q, vf_d;

    logic [WIDTH-1:0] bi;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             vb;
    logic [4:0]       s;
    logic [3:0]       dig;
    logic             dc;

    // Effective B/carry-in and the full binary sum of the incoming request
    always_comb begin
        bi  = bus.B;
        cin = bus.ci;
        unique case (bus.op)
            OP_SUB:  bi = ~bus.B;
            OP_INC:  begin bi = WIDTH'(1); cin = 1'b0; end
            OP_DEC:  begin bi = '1;        cin = 1'b0; end
            OP_CMP:  begin bi = ~bus.B;    cin = 1'b1; end
            default: ;
        endcase
        sum = {1'b0, bus.A} + {1'b0, bi} + {{WIDTH{1'b0}}, cin};
        vb  = (bus.A[MSB] == bi[MSB]) && (sum[MSB] != bus.A[MSB]);
    end

    // One decimal digit of the serial BCD adder/subtractor
    always_comb begin
        s   = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, c_q};
        dig = s[3:0];
        dc  = 1'b0;
        if (op_q == OP_SUB) begin
            dc = s[4];
            if (!s[4]) dig = s[3:0] - 4'd6;
        end else if (s > 5'd9) begin
            dig = s[3:0] + 4'd6;
            dc  = 1'b1;
        end
    end

    // Next-state, working registers and completion outputs
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        v_d     = v_q;
        rem_d   = rem_q;
        res_d   = res_q;
        cf_d    = cf_q;
        zf_d    = zf_q;
        nf_d    = nf_q;
        vf_d    = vf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.A;
                    b_d     = bi;
                    r_d     = sum[MSB:0];
                    c_d     = sum[WIDTH];
                    v_d     = vb;
                    rem_d   = '0;
                    state_d = BIN;
                    unique case (bus.op)
                        OP_ADD, OP_SUB: begin
                            if (bus.dec) begin
                                r_d     = '0;
                                c_d     = cin;
                                rem_d   = CW'(WIDTH / 4);
                                state_d = BCD;
                            end
                        end
                        OP_AND: begin r_d = bus.A & bus.B; c_d = bus.ci; v_d = 1'b0; end
                        OP_OR:  begin r_d = bus.A | bus.B; c_d = bus.ci; v_d = 1'b0; end
                        OP_EOR: begin r_d = bus.A ^ bus.B; c_d = bus.ci; v_d = 1'b0; end
                        OP_ASL, OP_LSR, OP_ROL, OP_ROR: begin
                            r_d     = bus.A;
                            c_d     = bus.ci;
                            v_d     = 1'b0;
                            rem_d   = bus.cnt;
                            state_d = SHF;
                        end
                        OP_INC, OP_DEC, OP_CMP: ;
                        default: begin r_d = bus.A; c_d = bus.ci; v_d = 1'b0; end
                    endcase
                end
            end
            BCD: begin
                if (rem_q != '0) begin
                    r_d   = {dig, r_q[MSB:4]};
                    a_d   = {4'h0, a_q[MSB:4]};
                    b_d   = {4'h0, b_q[MSB:4]};
                    c_d   = dc;
                    rem_d = rem_q - CW'(1);
                end
            end
            SHF: begin
                if (rem_q != '0) begin
                    unique case (op_q)
                        OP_ASL:  begin c_d = r_q[MSB]; r_d = {r_q[MSB-1:0], 1'b0}; end
                        OP_LSR:  begin c_d = r_q[0];   r_d = {1'b0, r_q[MSB:1]}; end
                        OP_ROL:  begin c_d = r_q[MSB]; r_d = {r_q[MSB-1:0], c_q}; end
                        default: begin c_d = r_q[0];   r_d = {c_q, r_q[MSB:1]}; end
                    endcase
                    rem_d = rem_q - CW'(1);
                end
            end
            default: ;
        endcase
        if (state_q != IDLE && rem_q == '0) begin
            res_d   = r_q;
            cf_d    = c_q;
            zf_d    = (r_q == '0);
            nf_d    = r_q[MSB];
            vf_d    = v_q;
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            rem_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
            vf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            v_q     <= v_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            done_q  <= done_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
            nf_q    <= nf_d;
            vf_q    <= vf_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.result = res_q;
    assign bus.C      = cf_q;
    assign bus.Z      = zf_q;
    assign bus.N      = nf_q;
    assign bus.V      = vf_q;
endmodule
